// File: rtl/pcie_phy_tx_framer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pcie_phy_tx_framer_pkg
// Brief    : Shared PCIe PHY constants, framer state encoding, DLLP packing.
// Revision : 1.0 - initial release
// ============================================================================
package pcie_phy_tx_framer_pkg;

  localparam logic [7:0] PCIE_K_STP = 8'hFB;  // K27.7
  localparam logic [7:0] PCIE_K_SDP = 8'h5C;  // K28.2
  localparam logic [7:0] PCIE_K_END = 8'hFD;  // K29.7

  localparam int TLP_FRAME_BEATS  = 9;
  localparam int DLLP_FRAME_BEATS = 2;

  typedef enum logic [1:0] {
    FR_IDLE    = 2'd0,
    FR_TLP_TX  = 2'd1,
    FR_DLLP_TX = 2'd2
  } framer_state_e;

  // First field is the MSB, so dllp_type lands on [47:40] (wire byte 0).
  typedef struct packed {
    logic [7:0]  dllp_type;
    logic [23:0] payload;
    logic [15:0] crc;
  } dllp_packet_t;

  function automatic logic [47:0] pcie_dllp_pack(input dllp_packet_t p);
    return {p.dllp_type, p.payload, p.crc};
  endfunction

endpackage
`default_nettype wire

// File: rtl/pcie_phy_tx_framer.sv
`default_nettype none
// ============================================================================
// Module   : pcie_phy_tx_framer
// Brief    : Gen1/2 STP/SDP..END TX framer, 4 bytes per beat with K flags.
// Revision : 1.0 - initial release
// ============================================================================
module pcie_phy_tx_framer
  import pcie_phy_tx_framer_pkg::*;
#(
  parameter int TLP_W  = 268,
  parameter int DLLP_W = 48
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tlp_valid_i,
  input  logic [TLP_W-1:0]  tlp_i,
  output logic              tlp_ready_o,
  input  logic              dllp_valid_i,
  input  logic [DLLP_W-1:0] dllp_i,
  output logic              dllp_ready_o,
  input  logic              phy_ready_i,
  output logic [31:0]       sym_o,
  output logic [3:0]        sym_k_o,
  output logic              sym_valid_o
);

  localparam int c_PAD_W = 272;
  // Beat 0 consumes the first three bytes; the rest wait in the shift buffer.
  localparam int c_BUF_W = c_PAD_W - 24;

  framer_state_e      r_state;
  logic [3:0]         r_cnt;
  logic [c_BUF_W-1:0] r_buf;
  logic [31:0]        r_sym;
  logic [3:0]         r_k;
  logic               r_vld;

  logic               w_idle;
  logic               w_dllp_acc;
  logic               w_tlp_acc;
  logic [c_PAD_W-1:0] w_padded;
  dllp_packet_t       w_dllp;
  logic [3:0]         w_last_idx;
  logic [3:0]         w_cnt_nxt;

  assign w_idle       = (r_state == FR_IDLE);
  // rst_n gating keeps both readies low while reset is held.
  assign dllp_ready_o = rst_n & w_idle & phy_ready_i;
  assign tlp_ready_o  = rst_n & w_idle & phy_ready_i & ~dllp_valid_i;
  assign w_dllp_acc   = dllp_valid_i & dllp_ready_o;
  assign w_tlp_acc    = tlp_valid_i & tlp_ready_o;

  assign w_padded   = {{(c_PAD_W-TLP_W){1'b0}}, tlp_i};
  assign w_dllp     = dllp_i;
  assign w_last_idx = (r_state == FR_TLP_TX) ? 4'(TLP_FRAME_BEATS - 1)
                                             : 4'(DLLP_FRAME_BEATS - 1);
  assign w_cnt_nxt  = r_cnt + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FR_IDLE;
      r_cnt   <= 4'd0;
      r_buf   <= '0;
      r_sym   <= 32'd0;
      r_k     <= 4'd0;
      r_vld   <= 1'b0;
    end else if (phy_ready_i) begin
      case (r_state)
        FR_IDLE: begin
          r_cnt <= 4'd0;
          if (w_dllp_acc) begin
            r_state <= FR_DLLP_TX;
            r_buf   <= {w_dllp.payload[7:0], w_dllp.crc, {(c_BUF_W-24){1'b0}}};
            r_sym   <= {w_dllp.payload[15:8], w_dllp.payload[23:16],
                        w_dllp.dllp_type, PCIE_K_SDP};
            r_k     <= 4'b0001;
            r_vld   <= 1'b1;
          end else if (w_tlp_acc) begin
            r_state <= FR_TLP_TX;
            r_buf   <= w_padded[c_BUF_W-1:0];
            r_sym   <= {w_padded[c_PAD_W-17 -: 8], w_padded[c_PAD_W-9 -: 8],
                        w_padded[c_PAD_W-1 -: 8], PCIE_K_STP};
            r_k     <= 4'b0001;
            r_vld   <= 1'b1;
          end else begin
            r_sym <= 32'd0;
            r_k   <= 4'd0;
            r_vld <= 1'b0;
          end
        end
        default: begin
          if (r_cnt == w_last_idx) begin
            r_state <= FR_IDLE;
            r_cnt   <= 4'd0;
            r_sym   <= 32'd0;
            r_k     <= 4'd0;
            r_vld   <= 1'b0;
          end else if (w_cnt_nxt == w_last_idx) begin
            // Closing beat: the last three buffered bytes plus END.
            r_cnt <= w_cnt_nxt;
            r_sym <= {PCIE_K_END, r_buf[c_BUF_W-17 -: 8],
                      r_buf[c_BUF_W-9 -: 8], r_buf[c_BUF_W-1 -: 8]};
            r_k   <= 4'b1000;
          end else begin
            r_cnt <= w_cnt_nxt;
            r_sym <= {r_buf[c_BUF_W-25 -: 8], r_buf[c_BUF_W-17 -: 8],
                      r_buf[c_BUF_W-9 -: 8], r_buf[c_BUF_W-1 -: 8]};
            r_k   <= 4'b0000;
            r_buf <= {r_buf[c_BUF_W-33:0], 32'd0};
          end
        end
      endcase
    end
  end

  assign sym_o       = r_sym;
  assign sym_k_o     = r_k;
  assign sym_valid_o = r_vld;

endmodule
`default_nettype wire

// File: tb/tb_pcie_phy_tx_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcie_phy_tx_framer
// Brief    : Directed self-checking bench for pcie_phy_tx_framer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcie_phy_tx_framer;
  import pcie_phy_tx_framer_pkg::*;

  logic         clk;
  logic         rst_n;
  logic         tlp_valid_i;
  logic [267:0] tlp_i;
  logic         tlp_ready_o;
  logic         dllp_valid_i;
  logic [47:0]  dllp_i;
  logic         dllp_ready_o;
  logic         phy_ready_i;
  logic [31:0]  sym_o;
  logic [3:0]   sym_k_o;
  logic         sym_valid_o;

  int n_checks;
  int n_errors;
  int n_tlp_acc;
  int n_dllp_acc;
  logic [36:0] obs [0:8];

  pcie_phy_tx_framer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tlp_valid_i  (tlp_valid_i),
    .tlp_i        (tlp_i),
    .tlp_ready_o  (tlp_ready_o),
    .dllp_valid_i (dllp_valid_i),
    .dllp_i       (dllp_i),
    .dllp_ready_o (dllp_ready_o),
    .phy_ready_i  (phy_ready_i),
    .sym_o        (sym_o),
    .sym_k_o      (sym_k_o),
    .sym_valid_o  (sym_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n) begin
      if (tlp_valid_i && tlp_ready_o)   n_tlp_acc  <= n_tlp_acc + 1;
      if (dllp_valid_i && dllp_ready_o) n_dllp_acc <= n_dllp_acc + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [36:0] beat_now();
    return {sym_valid_o, sym_k_o, sym_o};
  endfunction

  function automatic logic [7:0] tb_byte(input logic [267:0] t, input int j);
    logic [271:0] p;
    p = {4'b0, t};
    return p[271-8*j -: 8];
  endfunction

  // Reference framing of one TLP beat: {valid, k[3:0], sym[31:0]}.
  function automatic logic [36:0] tlp_beat(input logic [267:0] t, input int k);
    if (k == 0)
      return {1'b1, 4'b0001, tb_byte(t, 2), tb_byte(t, 1), tb_byte(t, 0), 8'hFB};
    else if (k == 8)
      return {1'b1, 4'b1000, 8'hFD, tb_byte(t, 33), tb_byte(t, 32), tb_byte(t, 31)};
    else
      return {1'b1, 4'b0000, tb_byte(t, 4*k+2), tb_byte(t, 4*k+1),
              tb_byte(t, 4*k), tb_byte(t, 4*k-1)};
  endfunction

  function automatic logic [267:0] make_tlp(input logic [11:0] seq, input logic [7:0] base,
                                            input logic [31:0] lcrc);
    logic [223:0] body;
    for (int i = 0; i < 28; i++) body[223-8*i -: 8] = base + 8'(i);
    return {seq, body, lcrc};
  endfunction

  task automatic send_tlp(input logic [267:0] t, input int stall_at, input int stop_at);
    check("tlp_rdy_pre", {63'b0, tlp_ready_o}, 64'd1);
    tlp_valid_i = 1'b1;
    tlp_i       = t;
    step();
    tlp_valid_i = 1'b0;
    tlp_i       = ~t;
    obs[0] = beat_now();
    check("tlp_b0", {27'b0, obs[0]}, {27'b0, tlp_beat(t, 0)});
    check("tlp_rdy_busy", {63'b0, tlp_ready_o}, 64'd0);
    for (int k = 1; k <= stop_at; k++) begin
      if (k - 1 == stall_at) begin
        phy_ready_i = 1'b0;
        for (int s = 0; s < 3; s++) begin
          step();
          check($sformatf("tlp_hold_b%0d_%0d", k-1, s), {27'b0, beat_now()},
                {27'b0, tlp_beat(t, k-1)});
        end
        check("dllp_rdy_stall", {63'b0, dllp_ready_o}, 64'd0);
        phy_ready_i = 1'b1;
      end
      step();
      obs[k] = beat_now();
      check($sformatf("tlp_b%0d", k), {27'b0, obs[k]}, {27'b0, tlp_beat(t, k)});
    end
    if (stop_at == 8) begin
      step();
      check("tlp_post_idle", {27'b0, beat_now()}, 64'd0);
      check("tlp_rdy_post", {63'b0, tlp_ready_o}, 64'd1);
    end
  endtask

  task automatic send_dllp(input logic [47:0] d, input logic [36:0] e0, input logic [36:0] e1);
    check("dllp_rdy_pre", {63'b0, dllp_ready_o}, 64'd1);
    dllp_valid_i = 1'b1;
    dllp_i       = d;
    step();
    dllp_valid_i = 1'b0;
    dllp_i       = ~d;
    check("dllp_b0", {27'b0, beat_now()}, {27'b0, e0});
    check("dllp_rdy_busy", {63'b0, dllp_ready_o}, 64'd0);
    step();
    check("dllp_b1", {27'b0, beat_now()}, {27'b0, e1});
  endtask

  initial begin
    logic [267:0] t1, t2, t3, t4;
    logic [47:0]  d1;
    dllp_packet_t dp;
    int           tlp0, dllp0;

    n_checks = 0; n_errors = 0; n_tlp_acc = 0; n_dllp_acc = 0;
    rst_n = 1'b0; phy_ready_i = 1'b1;
    tlp_valid_i = 1'b0; tlp_i = '0; dllp_valid_i = 1'b0; dllp_i = '0;

    // Reset and idle behaviour
    step(); step();
    check("rst_beat", {27'b0, beat_now()}, 64'd0);
    check("rst_tlp_rdy", {63'b0, tlp_ready_o}, 64'd0);
    check("rst_dllp_rdy", {63'b0, dllp_ready_o}, 64'd0);
    rst_n = 1'b1; phy_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("idle_beat_%0d", i), {27'b0, beat_now()}, 64'd0);
    end
    check("idle_rdy_stalled", {62'b0, tlp_ready_o, dllp_ready_o}, 64'd0);
    phy_ready_i = 1'b1;
    #1;
    check("idle_rdy", {62'b0, tlp_ready_o, dllp_ready_o}, 64'd3);

    // Basic TLP frame
    t1 = make_tlp(12'hABC, 8'h00, 32'hDEADBEEF);
    send_tlp(t1, -1, 8);
    check("tlp1_b0_const", {27'b0, obs[0]}, {27'b0, 1'b1, 4'b0001, 32'h00BC0AFB});
    check("tlp1_b1_const", {27'b0, obs[1]}, {27'b0, 1'b1, 4'b0000, 32'h04030201});
    check("tlp1_b7_const", {27'b0, obs[7]}, {27'b0, 1'b1, 4'b0000, 32'hDE1B1A19});
    check("tlp1_b8_const", {27'b0, obs[8]}, {27'b0, 1'b1, 4'b1000, 32'hFDEFBEAD});

    // Basic DLLP frame
    dp.dllp_type = 8'h00; dp.payload = 24'h001234; dp.crc = 16'h5678;
    d1 = pcie_dllp_pack(dp);
    send_dllp(d1, {1'b1, 4'b0001, 32'h1200005C}, {1'b1, 4'b1000, 32'hFD785634});
    step();
    check("dllp_post_idle", {27'b0, beat_now()}, 64'd0);

    // Simultaneous offer: DLLP wins, TLP follows after one idle beat
    t2 = make_tlp(12'h123, 8'hA0, 32'h0BADF00D);
    tlp0 = n_tlp_acc; dllp0 = n_dllp_acc;
    tlp_valid_i = 1'b1; tlp_i = t2;
    dllp_valid_i = 1'b1; dllp_i = 48'h01_AABBCC_1357;
    #1;
    check("both_tlp_rdy", {63'b0, tlp_ready_o}, 64'd0);
    step();
    dllp_valid_i = 1'b0;
    check("both_dllp_b0", {27'b0, beat_now()}, {27'b0, 1'b1, 4'b0001, 32'hBBAA015C});
    step();
    check("both_dllp_b1", {27'b0, beat_now()}, {27'b0, 1'b1, 4'b1000, 32'hFD5713CC});
    step();
    check("both_gap_idle", {27'b0, beat_now()}, 64'd0);
    send_tlp(t2, -1, 8);
    check("both_tlp_once", 64'(n_tlp_acc - tlp0), 64'd1);
    check("both_dllp_once", 64'(n_dllp_acc - dllp0), 64'd1);

    // PHY stall during beat 4
    t3 = make_tlp(12'h5E7, 8'h40, 32'h89ABCDEF);
    send_tlp(t3, 4, 8);

    // Asynchronous reset during beat 6, then a clean frame
    send_tlp(t1, -1, 6);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_beat", {27'b0, beat_now()}, 64'd0);
    check("midrst_rdy", {62'b0, tlp_ready_o, dllp_ready_o}, 64'd0);
    step();
    rst_n = 1'b1;
    step();
    check("postrst_idle", {27'b0, beat_now()}, 64'd0);
    t4 = make_tlp(12'hF01, 8'hC3, 32'h13579BDF);
    send_tlp(t4, -1, 8);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pcie_phy_tx_framer.md
Name: pcie_phy_tx_framer

Overview:
- Physical-layer TX framer directly downstream of the DLL TX stage.
- Consumes sequenced, LCRC-protected TLPs (268 bits: 12-bit seq + 224-bit TLP + 32-bit LCRC) and 48-bit DLLPs.
- Wraps each packet in Gen1/2 STP/SDP...END framing and streams it as 4 bytes/beat, with K-flags, to the lane striper/8b10b encoder.
- Emits logical-idle beats when no packet is pending.

Parameters:
- TLP_W, 268, width of the sequenced TLP from DLL TX.
- DLLP_W, 48, width of a DLLP (type + 3 payload bytes + 16-bit CRC).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- tlp_valid_i  in  1  TLP offered by DLL TX.
- tlp_i  in  268  [267:256]=seq, [255:32]=TLP hdr/data, [31:0]=LCRC.
- tlp_ready_o  out  1  TLP accepted when valid & ready.
- dllp_valid_i  in  1  DLLP offered.
- dllp_i  in  48  DLLP, byte 0 = [47:40].
- dllp_ready_o  out  1  DLLP accepted when valid & ready.
- phy_ready_i  in  1  PHY takes the current beat; low stalls the framer.
- sym_o  out  32  output bytes, lane 0 = [7:0] is the first byte on the wire.
- sym_k_o  out  4  per-byte K-symbol flag.
- sym_valid_o  out  1  beat carries framed content (0 = logical idle).

Behaviour:
- Reset (async assert, sync release): state=IDLE, sym_o=0, sym_k_o=0, sym_valid_o=0, tlp_ready_o=0, dllp_ready_o=0, beat counter=0, shift registers cleared.
- All outputs are registered. The output register advances only on cycles with phy_ready_i=1; otherwise every output and internal state holds.
- States: IDLE, TLP_TX, DLLP_TX.
- IDLE:
  - dllp_ready_o = phy_ready_i.
  - tlp_ready_o = phy_ready_i & ~dllp_valid_i. DLLPs have strict priority at frame boundaries.
  - On a DLLP accept: load the DLLP, go to DLLP_TX, drive beat 0 next cycle.
  - Else on a TLP accept: load the frame buffer, go to TLP_TX, drive beat 0 next cycle.
  - Else drive the idle beat: sym_o=0, sym_k_o=0, sym_valid_o=0.
- Both ready outputs are 0 in every state except IDLE. This guarantees at least one idle beat between frames.
- TLP frame:
  - The 272-bit padded word is {4'b0, tlp_i}. Byte bk = padded[271-8k -: 8], k=0..33. b0 = {4'b0, seq[11:8]}, b1 = seq[7:0].
  - Nine beats, counter 0..8:
    - beat 0 = {b2, b1, b0, STP}, k=4'b0001.
    - beats 1..7 = next 4 bytes each (b3..b30), k=0.
    - beat 8 = {END, b33, b32, b31}, k=4'b1000.
  - After beat 8 is taken, return to IDLE.
- DLLP frame:
  - Bytes d0..d5 taken MSB-first from dllp_i.
  - Two beats:
    - beat 0 = {d2, d1, d0, SDP}, k=4'b0001.
    - beat 1 = {END, d5, d4, d3}, k=4'b1000.
  - After beat 1 is taken, return to IDLE.
- sym_valid_o=1 on every framed beat.
- K codes: STP=8'hFB (K27.7), SDP=8'h5C (K28.2), END=8'hFD (K29.7). Idle data is 8'h00 with k=0.
- Latency: accept at cycle N -> beat 0 on sym_o at N+1 (with phy_ready_i held high).
- Simultaneous TLP and DLLP valid in IDLE: the DLLP is accepted and the TLP waits. The TLP is accepted in the next IDLE window with no DLLP pending.
- A DLLP arriving mid-TLP waits; frames are never preempted.
- A phy_ready_i drop mid-frame freezes the beat; it resumes with no byte loss or duplication.
- Reset mid-frame aborts the frame immediately; outputs go to idle values. No truncation marker (EDB) is generated.
- tlp_i and dllp_i need not stay stable after acceptance; they are captured on accept.

Decomposition:
- Add to the shared PCIe package:
  - K-symbol constants (PCIE_K_STP, PCIE_K_SDP, PCIE_K_END).
  - Frame beat counts (TLP_FRAME_BEATS=9, DLLP_FRAME_BEATS=2).
  - The framer state enum.
  - dllp_i packing order, so it matches the existing dllp_packet struct (add a pack function).
- Single module; no sub-module is warranted.

Test Plan:
- Reset then 5 idle cycles -> sym_o=0, sym_k_o=0, sym_valid_o=0, both readies high once phy_ready_i=1.
- TLP: seq=12'hABC, TLP bytes 8'h00..8'h1B, LCRC=32'hDEADBEEF -> next cycle beat0 = 32'h00BC0AFB, k=0001. Beat 8 = 32'hFDEFBEAD, k=1000. Exactly 9 beats, then an idle beat.
- DLLP 48'h00_0012_34_5678 -> beats 32'h1200005C (k=0001), then 32'hFD785634 (k=1000).
- TLP and DLLP valid in the same IDLE cycle -> DLLP frame (2 beats), 1 idle beat, then TLP frame; each accepted exactly once.
- phy_ready_i low for 3 cycles during TLP beat 4 -> beat 4 held for 3 cycles, then beats 5..8 in order; a reference-model byte compare passes.
- rst_n asserted asynchronously during beat 6 -> outputs zero immediately; after release the framer returns to IDLE and the next TLP frames correctly.
